pool_engine_nch: RTL and testbench
==================================

Name: pool_engine_nch

Overview:
Parametrised streaming pooling engine and successor to the single-channel 2x2 max-pool stage. It takes a raster-order feature map with channels interleaved channel-fastest and applies non-overlapping POOLxPOOL windows with stride POOL. Max or average mode is selected per frame. It sits between a conv/activation stage and the next layer, uses valid/ready handshakes on both sides, and reports end-of-frame.

Parameters:
DATA_W, 8, signed pixel width (two's complement)
MAP_W, 28, input map width in pixels
MAP_H, 28, input map height in pixels
CHANNELS, 1, channels interleaved per pixel position (channel index fastest)
POOL, 2, window edge and stride; power of two, 2..8
OUT_W, MAP_W/POOL, output width (floor)
OUT_H, MAP_H/POOL, output height (floor)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mode  in  1  0 = max, 1 = average; sampled on first accepted pixel of a frame
in_valid  in  1  input pixel valid
in_ready  out  1  engine can accept pixel
in_pixel  in  DATA_W  signed input pixel
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_pixel  out  DATA_W  signed pooled result
out_last  out  1  qualifies last output of frame (with out_valid)
frame_done  out  1  one-cycle pulse after last output of frame accepted
busy  out  1  high from first accepted pixel until frame_done

Behaviour:
- Reset values (async assert, sync release): in_ready=1, out_valid=0, out_pixel=0, out_last=0, frame_done=0, busy=0. All counters and the latched mode are 0; accumulator contents are don't-care.
- Handshake: a pixel is accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This gives a single output register with combinational pass-through of backpressure.
- out_pixel and out_last are held stable while out_valid && !out_ready.
- Counters ch (0..CHANNELS-1), col (0..MAP_W-1) and row (0..MAP_H-1) advance only on acceptance. Wrap order is ch, then col, then row. row wraps to 0 at frame end.
- Floor mode: pixels with col >= OUT_W*POOL or row >= OUT_H*POOL are accepted and counted but do not affect outputs.
- Accumulator RAM: OUT_W*CHANNELS entries, indexed by (col/POOL, ch).
  - Entry width is DATA_W+2*log2(POOL), signed.
  - Max mode uses only the low DATA_W bits, sign-extended.
- Per accepted in-range pixel, with window position wr=row%POOL, wc=col%POOL:
  - wr==0 && wc==0: entry <= pixel (sign-extended).
  - Else if not (wr==POOL-1 && wc==POOL-1): entry <= combine(entry, pixel).
  - wr==POOL-1 && wc==POOL-1: result = combine(entry, pixel). out_valid<=1 and out_pixel<=final(result) on the next edge (latency 1 cycle from accepting the window's last pixel).
- combine: max mode returns the signed maximum. Average mode returns the full-width signed sum; overflow is impossible by construction.
- final: max mode returns the value unchanged. Average mode returns sum >>> (2*log2(POOL)), arithmetic shift (floor toward negative infinity), truncated to DATA_W.
- Output order is raster over (out_row, out_col), with channel fastest.
- out_last=1 on the output produced by the window at out_row=OUT_H-1, out_col=OUT_W-1, ch=CHANNELS-1.
- mode is latched on the first accepted pixel of a frame (all counters 0) and held until the frame ends. Changes mid-frame are ignored.
- frame_done pulses on the cycle after the out_last transfer. busy falls in the same cycle. A new frame's pixels may be accepted from the cycle the out_last transfer occurs. If MAP_H has trailing floor rows, frame_done still follows the out_last transfer, but busy stays high until the last input pixel is accepted.
- Simultaneous output transfer and a new window completion in the same cycle: the register is reloaded with out_valid staying 1, giving no bubble.
- Reset mid-frame: all state clears immediately. A partial output is dropped, and the next accepted pixel is treated as frame pixel (0,0,ch0).

Test Plan:
- Max, defaults, map of 4x4 with rows [1,5,2,0],[3,-7,8,4],[-1,-2,-3,-4],[-5,-6,-8,-128] (DATA_W=8, MAP_W=MAP_H=4) -> outputs 5, 8, -1, -3. out_last on the 4th output, then frame_done one cycle later.
- Average, POOL=2, window {-1,-2,-2,-2} -> sum -7, out_pixel -2 (floor). Window {127,127,127,127} -> 127.
- CHANNELS=3, MAP 4x4, ch0 all 10, ch1 all -20, ch2 ramp 0..15 in max mode -> per window the outputs are 10, -20, max ramp; full sequence 10,-20,5, 10,-20,7, 10,-20,13, 10,-20,15.
- Backpressure: hold out_ready=0 for 5 cycles while a result is pending -> in_ready=0, out_pixel stable, no input lost. Release -> data intact and stream resumes.
- MAP_W=5, MAP_H=5, POOL=2, max -> exactly 4 outputs. Column 4 and row 4 values (set to 127) never appear. frame_done after the 4th output, busy high until the 25th pixel.
- Assert rst for 1 cycle after 6 pixels, then stream a full frame -> outputs match the clean-frame golden. No stray out_valid occurs during or after reset.

Source files
------------

// File: rtl/pool_engine_nch.sv
// pool_engine_nch: streaming POOLxPOOL max/average pooling over a channel-interleaved raster map
module pool_engine_nch #(
  parameter int DATA_W   = 8,
  parameter int MAP_W    = 28,
  parameter int MAP_H    = 28,
  parameter int CHANNELS = 1,
  parameter int POOL     = 2,
  parameter int OUT_W    = MAP_W / POOL,
  parameter int OUT_H    = MAP_H / POOL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_pixel,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     busy
);
  localparam int LG    = $clog2(POOL);
  localparam int ACC_W = DATA_W + 2 * LG;
  localparam int DEPTH = OUT_W * CHANNELS;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CH_W  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int COL_W = MAP_W > 1 ? $clog2(MAP_W) : 1;
  localparam int ROW_W = MAP_H > 1 ? $clog2(MAP_H) : 1;

  logic [CH_W-1:0]           r_ch;
  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic                      r_mode;
  logic                      r_out_open;
  logic                      r_out_valid;
  logic [DATA_W-1:0]         r_out_pixel;
  logic                      r_out_last;
  logic                      r_frame_done;
  logic signed [ACC_W-1:0]   r_acc [DEPTH];

  logic                      w_accept;
  logic                      w_first;
  logic                      w_mode;
  logic                      w_ch_end;
  logic                      w_col_end;
  logic                      w_row_end;
  logic                      w_in_range;
  logic [LG-1:0]             w_wr;
  logic [LG-1:0]             w_wc;
  logic                      w_win_start;
  logic                      w_win_end;
  logic                      w_last_win;
  logic                      w_last_xfer;
  logic [IDX_W-1:0]          w_idx;
  logic signed [ACC_W-1:0]   w_px;
  logic signed [ACC_W-1:0]   w_entry;
  logic signed [ACC_W-1:0]   w_entry_m;
  logic signed [ACC_W-1:0]   w_comb;
  logic [DATA_W-1:0]         w_final;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_first     = r_ch == '0 && r_col == '0 && r_row == '0;
  assign w_mode      = w_first ? mode : r_mode;
  assign w_ch_end    = r_ch == CH_W'(CHANNELS - 1);
  assign w_col_end   = r_col == COL_W'(MAP_W - 1);
  assign w_row_end   = r_row == ROW_W'(MAP_H - 1);
  assign w_in_range  = int'(r_col) < OUT_W * POOL && int'(r_row) < OUT_H * POOL;
  assign w_wr        = r_row[LG-1:0];
  assign w_wc        = r_col[LG-1:0];
  assign w_win_start = w_wr == '0 && w_wc == '0;
  assign w_win_end   = &w_wr && &w_wc;
  assign w_last_win  = int'(r_row >> LG) == OUT_H - 1 && int'(r_col >> LG) == OUT_W - 1 && w_ch_end;
  assign w_idx       = IDX_W'(int'(r_col >> LG) * CHANNELS + int'(r_ch));
  assign w_px        = ACC_W'(in_pixel);
  assign w_entry     = r_acc[w_idx];
  assign w_entry_m   = ACC_W'(signed'(w_entry[DATA_W-1:0]));
  assign w_comb      = w_mode ? w_entry + w_px : (w_px > w_entry_m ? w_px : w_entry_m);
  assign w_final     = DATA_W'(w_mode ? (w_comb >>> (2 * LG)) : w_comb);
  assign w_last_xfer = r_out_valid && out_ready && r_out_last;

  assign out_valid   = r_out_valid;
  assign out_pixel   = r_out_pixel;
  assign out_last    = r_out_last;
  assign frame_done  = r_frame_done;
  assign busy        = r_out_open || !w_first;

  // frame position counters (channel fastest) and per-frame mode latch advance on acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ch   <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= 1'b0;
    end else if (w_accept) begin
      if (w_first) r_mode <= mode;
      r_ch <= w_ch_end ? '0 : r_ch + 1'b1;
      if (w_ch_end) r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_ch_end && w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
    end

  // frame output window stays open from first pixel until the out_last transfer
  always_ff @(posedge clk or posedge rst)
    if (rst) r_out_open <= 1'b0;
    else if (w_accept && w_first) r_out_open <= 1'b1;
    else if (w_last_xfer) r_out_open <= 1'b0;

  // single output register, reloaded without a bubble when a window completes during a transfer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_xfer;
      if (w_accept && w_in_range && w_win_end) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_final;
        r_out_last  <= w_last_win;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end

  // partial window results per (output column, channel); window end bypasses the write
  always_ff @(posedge clk)
    if (w_accept && w_in_range && !w_win_end) r_acc[w_idx] <= w_win_start ? w_px : w_comb;
endmodule

// File: tb/tb_pool_engine_nch.sv
// tb_pool_engine_nch: table vectors on a 4x4 map plus randomized multi-channel frames with floor rows/cols
module tb_pool_engine_nch;
  logic clk, rst;
  logic a_mode, a_iv, a_ir, a_ov, a_or, a_ol, a_fd, a_busy;
  logic [7:0] a_px, a_op;
  logic b_mode, b_iv, b_ir, b_ov, b_or, b_ol, b_fd, b_busy;
  logic [7:0] b_px, b_op;

  pool_engine_nch #(.DATA_W(8), .MAP_W(4), .MAP_H(4), .CHANNELS(1), .POOL(2)) u0 (
    .clk(clk), .rst(rst), .mode(a_mode), .in_valid(a_iv), .in_ready(a_ir), .in_pixel(a_px),
    .out_valid(a_ov), .out_ready(a_or), .out_pixel(a_op), .out_last(a_ol),
    .frame_done(a_fd), .busy(a_busy));

  pool_engine_nch #(.DATA_W(8), .MAP_W(10), .MAP_H(9), .CHANNELS(3), .POOL(4)) u1 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_iv), .in_ready(b_ir), .in_pixel(b_px),
    .out_valid(b_ov), .out_ready(b_or), .out_pixel(b_op), .out_last(b_ol),
    .frame_done(b_fd), .busy(b_busy));

  typedef struct packed {
    logic             mode;
    logic [0:15][7:0] px;
    logic [0:3][7:0]  exp;
  } vec_t;

  vec_t tv[4];
  int total = 0, bad = 0;
  logic [8:0] aq[$], bq[$];
  logic afd[$], bfd[$];
  logic a_prev = 0, b_prev = 0;
  logic b_run;
  int fp[9][10][3];
  int expq[$];

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (a_ov && a_or) aq.push_back({a_ol, a_op});
    if (a_fd) afd.push_back(a_prev);
    a_prev = a_ov && a_or && a_ol;
    if (b_ov && b_or) bq.push_back({b_ol, b_op});
    if (b_fd) bfd.push_back(b_prev);
    b_prev = b_ov && b_or && b_ol;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic push_a(input logic m, input logic [7:0] p);
    logic acc = 0;
    a_mode = m; a_px = p; a_iv = 1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = a_ir;
      step();
    end
    if (!acc) chk("push_a_timeout", 0, 1);
    a_iv = 0;
  endtask

  task automatic push_b(input logic m, input logic [7:0] p);
    logic acc = 0;
    b_mode = m; b_px = p; b_iv = 1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = b_ir;
      step();
    end
    if (!acc) chk("push_b_timeout", 0, 1);
    b_iv = 0;
  endtask

  task automatic check_a(input int v);
    chk("a_count", aq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < aq.size()) begin
        chk("a_pixel", $signed(aq[i][7:0]), $signed(tv[v].exp[i]));
        chk("a_last", int'(aq[i][8]), int'(i == 3));
      end
    chk("a_frame_done_count", afd.size(), 1);
    if (afd.size() > 0) chk("a_frame_done_after_last", int'(afd[0]), 1);
    chk("a_busy_end", a_busy, 0);
  endtask

  task automatic run_a(input int v);
    aq.delete(); afd.delete();
    for (int k = 0; k < 16; k++) begin
      push_a(k == 0 ? tv[v].mode : ~tv[v].mode, tv[v].px[k]);
      if (k == 0) chk("a_busy_start", a_busy, 1);
    end
    repeat (6) step();
    check_a(v);
  endtask

  initial begin
    tv[0].mode = 0;
    tv[0].px  = {8'(1), 8'(5), 8'(2), 8'(0), 8'(3), 8'(-7), 8'(8), 8'(4),
                 8'(-1), 8'(-2), 8'(-3), 8'(-4), 8'(-5), 8'(-6), 8'(-8), 8'(-128)};
    tv[0].exp = {8'(5), 8'(8), 8'(-1), 8'(-3)};
    tv[1].mode = 1;
    tv[1].px  = tv[0].px;
    tv[1].exp = {8'(0), 8'(3), 8'(-4), 8'(-36)};
    tv[2].mode = 1;
    tv[2].px  = {8'(-1), 8'(-2), 8'(127), 8'(127), 8'(-2), 8'(-2), 8'(127), 8'(127),
                 8'(-128), 8'(-128), 8'(0), 8'(0), 8'(-128), 8'(-128), 8'(0), 8'(1)};
    tv[2].exp = {8'(-2), 8'(127), 8'(-128), 8'(0)};
    tv[3].mode = 0;
    tv[3].px  = {8'(-128), 8'(-128), 8'(127), 8'(-1), 8'(-128), 8'(-127), 8'(0), 8'(-2),
                 8'(0), 8'(-1), 8'(-3), 8'(-3), 8'(-1), 8'(-1), 8'(-3), 8'(-3)};
    tv[3].exp = {8'(-127), 8'(127), 8'(0), 8'(-3)};

    rst = 1; a_mode = 0; a_iv = 0; a_px = 0; a_or = 1;
    b_mode = 0; b_iv = 0; b_px = 0; b_or = 1; b_run = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out_pixel", a_op, 0);
    chk("rst_out_last", a_ol, 0);
    chk("rst_frame_done", a_fd, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_out_valid", b_ov, 0);

    for (int v = 0; v < 4; v++) run_a(v);

    aq.delete(); afd.delete();
    for (int k = 0; k < 6; k++) push_a(0, tv[0].px[k]);
    a_or = 0; a_iv = 1; a_px = tv[0].px[6];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", a_ir, 0);
      chk("bp_out_valid", a_ov, 1);
      chk("bp_hold_pixel", $signed(a_op), 5);
    end
    step();
    a_or = 1;
    for (int k = 6; k < 16; k++) push_a(1, tv[0].px[k]);
    repeat (6) step();
    check_a(0);

    for (int k = 0; k < 6; k++) push_a(1, tv[2].px[k]);
    rst = 1;
    #1;
    chk("mid_rst_out_valid", a_ov, 0);
    chk("mid_rst_busy", a_busy, 0);
    step();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", a_ov, 0);
    end
    step();
    run_a(0);

    for (int f = 0; f < 4; f++) begin
      logic m;
      m = (f % 2 == 1);
      for (int r = 0; r < 9; r++)
        for (int c = 0; c < 10; c++)
          for (int ch = 0; ch < 3; ch++) begin
            int k;
            k = $urandom_range(0, 7);
            fp[r][c][ch] = k == 0 ? -128 : k == 1 ? 127 : int'($urandom_range(0, 255)) - 128;
          end
      expq.delete();
      for (int orow = 0; orow < 2; orow++)
        for (int ocol = 0; ocol < 2; ocol++)
          for (int ch = 0; ch < 3; ch++) begin
            int s, mx;
            s = 0; mx = -1000;
            for (int dr = 0; dr < 4; dr++)
              for (int dc = 0; dc < 4; dc++) begin
                s += fp[orow*4+dr][ocol*4+dc][ch];
                if (fp[orow*4+dr][ocol*4+dc][ch] > mx) mx = fp[orow*4+dr][ocol*4+dc][ch];
              end
            expq.push_back(m ? (s - (((s % 16) + 16) % 16)) / 16 : mx);
          end
      bq.delete(); bfd.delete();
      b_run = 1;
      fork
        begin
          for (int n = 0; n < 270; n++) begin
            if ($urandom_range(0, 3) == 0) step();
            push_b(n == 0 ? m : 1'($urandom_range(0, 1)), 8'(fp[n/30][(n/3)%10][n%3]));
            if (n == 268) chk("b_busy_before_last_pixel", b_busy, 1);
          end
          chk("b_busy_after_last_pixel", b_busy, 0);
          b_run = 0;
        end
        begin
          while (b_run) begin
            b_or = $urandom_range(0, 3) != 0;
            step();
          end
          b_or = 1;
        end
      join
      repeat (6) step();
      chk("b_count", bq.size(), 12);
      for (int i = 0; i < 12; i++)
        if (i < bq.size()) begin
          chk("b_pixel", $signed(bq[i][7:0]), expq[i]);
          chk("b_last", int'(bq[i][8]), int'(i == 11));
        end
      chk("b_frame_done_count", bfd.size(), 1);
      if (bfd.size() > 0) chk("b_frame_done_after_last", int'(bfd[0]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
